// File: rtl/fpga_synth_avm_pkg.sv
// Shared types and sizing constants for the synth Avalon-MM control initiator.
// Latency: none (types only); backpressure: n/a.
package fpga_synth_avm_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RDWAIT = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam int READ_LATENCY_MAX = 3;
  localparam int LAT_CNT_W        = 2;
  localparam int TO_CNT_W         = 8;

endpackage

// File: rtl/fpga_synth_avm_initiator.sv
// Single-outstanding Avalon-MM initiator: one command becomes one transfer, one response pulse.
// Latency 2 cycles (+READ_LATENCY on reads, +stalls); cmd_ready only in IDLE, no response backpressure.
module fpga_synth_avm_initiator
  import fpga_synth_avm_pkg::*;
#(
  parameter int ADDR_W       = 2,
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 0,
  parameter int TIMEOUT      = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_address,
  input  logic [DATA_W-1:0] cmd_writedata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_readdata,
  output logic              rsp_error,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [DATA_W-1:0] avm_writedata,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              avm_waitrequest,
  output logic              busy
);

  localparam logic [TO_CNT_W-1:0]  TO_LAST  = TO_CNT_W'(TIMEOUT - 1);
  localparam logic [LAT_CNT_W-1:0] LAT_LAST = LAT_CNT_W'((READ_LATENCY > 0) ? READ_LATENCY - 1 : 0);

  state_t               state;
  logic [TO_CNT_W-1:0]  to_cnt;
  logic [LAT_CNT_W-1:0] lat_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      to_cnt        <= '0;
      lat_cnt       <= '0;
      cmd_ready     <= 1'b0;
      busy          <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_error     <= 1'b0;
      rsp_readdata  <= '0;
      avm_address   <= '0;
      avm_read      <= 1'b0;
      avm_write     <= 1'b0;
      avm_writedata <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            state         <= ACCESS;
            cmd_ready     <= 1'b0;
            busy          <= 1'b1;
            to_cnt        <= '0;
            avm_address   <= cmd_address;
            avm_writedata <= cmd_write ? cmd_writedata : '0;
            avm_write     <= cmd_write;
            avm_read      <= ~cmd_write;
          end
        end

        ACCESS: begin
          if (avm_waitrequest) begin
            // Abort on the TIMEOUT-th stalled cycle; the slave never saw a completed transfer.
            if (to_cnt == TO_LAST) begin
              state        <= RESP;
              avm_read     <= 1'b0;
              avm_write    <= 1'b0;
              rsp_valid    <= 1'b1;
              rsp_error    <= 1'b1;
              rsp_readdata <= '0;
            end else begin
              to_cnt <= to_cnt + 1'b1;
            end
          end else begin
            avm_read  <= 1'b0;
            avm_write <= 1'b0;
            if (avm_write || READ_LATENCY == 0) begin
              state        <= RESP;
              rsp_valid    <= 1'b1;
              rsp_error    <= 1'b0;
              rsp_readdata <= avm_write ? '0 : avm_readdata;
            end else begin
              state   <= RDWAIT;
              lat_cnt <= '0;
            end
          end
        end

        RDWAIT: begin
          if (lat_cnt == LAT_LAST) begin
            state        <= RESP;
            rsp_valid    <= 1'b1;
            rsp_error    <= 1'b0;
            rsp_readdata <= avm_readdata;
          end else begin
            lat_cnt <= lat_cnt + 1'b1;
          end
        end

        RESP: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
        end

        default: begin
          state     <= IDLE;
          cmd_ready <= 1'b0;
          busy      <= 1'b0;
          avm_read  <= 1'b0;
          avm_write <= 1'b0;
        end
      endcase
    end
  end

endmodule
